// File: rtl/top.sv
// Registered IEEE-754 binary32 multiplier with selectable rounding mode,
// gradual underflow and saturating overflow behaviour per rounding direction.
module top #(
    parameter int WIDTH     = 32,
    parameter int EXP_WIDTH = 8,
    parameter int SIG_WIDTH = 23,
    parameter int BIAS      = 127
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       rnd,
    output logic [WIDTH-1:0] result
);

    localparam int MW  = SIG_WIDTH + 1;
    localparam int PW  = 2 * MW;
    localparam int EW  = EXP_WIDTH + 4;
    localparam int LZW = $clog2(PW);
    localparam int SHW = $clog2(PW + 2);
    localparam int PKW = EW + SIG_WIDTH;

    typedef enum logic [1:0] {
        RNE = 2'b00,
        RTZ = 2'b01,
        RUP = 2'b10,
        RDN = 2'b11
    } rnd_e;

    rnd_e                 mode;
    logic                 sign;
    logic [EXP_WIDTH-1:0] exp_a, exp_b;
    logic [SIG_WIDTH-1:0] frac_a, frac_b;
    logic                 exp_a_zero, exp_b_zero;
    logic                 nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic [PW-1:0]        prod, norm, aligned;
    logic [LZW-1:0]       lz;
    logic [EW-1:0]        exp_norm, sh_raw, exp_base;
    logic                 tiny;
    logic [SHW-1:0]       sh;
    logic [MW-1:0]        kept;
    logic                 guard, round_b, sticky, lost, inexact, inc;
    logic [MW:0]          rounded;
    logic [PKW-1:0]       packed_res;
    logic                 overflow;
    logic [WIDTH-1:0]     inf_val, max_val, ovf_val, qnan_val;
    logic [WIDTH-1:0]     result_d, result_q;

    assign mode   = rnd_e'(rnd);
    assign sign   = A[WIDTH-1] ^ B[WIDTH-1];
    assign exp_a  = A[WIDTH-2 -: EXP_WIDTH];
    assign exp_b  = B[WIDTH-2 -: EXP_WIDTH];
    assign frac_a = A[SIG_WIDTH-1:0];
    assign frac_b = B[SIG_WIDTH-1:0];

    assign exp_a_zero = ~|exp_a;
    assign exp_b_zero = ~|exp_b;
    assign nan_a  = (&exp_a) & (|frac_a);
    assign nan_b  = (&exp_b) & (|frac_b);
    assign inf_a  = (&exp_a) & ~(|frac_a);
    assign inf_b  = (&exp_b) & ~(|frac_b);
    assign zero_a = exp_a_zero & ~(|frac_a);
    assign zero_b = exp_b_zero & ~(|frac_b);

    assign prod = PW'({~exp_a_zero, frac_a}) * PW'({~exp_b_zero, frac_b});

    // Highest set bit wins, so the loop ends holding the leading-zero count.
    always_comb begin
        lz = '0;
        for (int i = 0; i < PW; i++) begin
            if (prod[i]) lz = LZW'(PW - 1 - i);
        end
    end

    always_comb begin
        exp_norm = (exp_a_zero ? EW'(1) : EW'(exp_a))
                 + (exp_b_zero ? EW'(1) : EW'(exp_b))
                 - EW'(BIAS) + EW'(1) - EW'(lz);
        tiny     = exp_norm[EW-1] | (exp_norm == '0);
        sh_raw   = EW'(1) - exp_norm;
        sh       = '0;
        if (tiny) sh = (sh_raw > EW'(PW + 1)) ? SHW'(PW + 1) : sh_raw[SHW-1:0];
        exp_base = tiny ? '0 : exp_norm - EW'(1);
    end

    // Denormalizing shift keeps every discarded bit alive in the sticky term.
    always_comb begin
        norm    = prod << lz;
        aligned = norm >> sh;
        lost    = |(norm & ~({PW{1'b1}} << sh));
        kept    = aligned[PW-1 -: MW];
        guard   = aligned[PW-MW-1];
        round_b = aligned[PW-MW-2];
        sticky  = (|aligned[PW-MW-3:0]) | lost;
        inexact = guard | round_b | sticky;
        inc     = 1'b0;
        case (mode)
            RNE:     inc = guard & (round_b | sticky | kept[0]);
            RTZ:     inc = 1'b0;
            RUP:     inc = ~sign & inexact;
            RDN:     inc = sign & inexact;
            default: inc = 1'b0;
        endcase
        rounded = {1'b0, kept} + (MW + 1)'(inc);
    end

    // Adding the hidden bit onto the exponent field absorbs both a rounding
    // carry-out and a subnormal rounding up into the smallest normal.
    assign packed_res = {exp_base, {SIG_WIDTH{1'b0}}} + PKW'(rounded);
    assign overflow   = packed_res[PKW-1:SIG_WIDTH] >= EW'((1 << EXP_WIDTH) - 1);

    assign inf_val  = {sign, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
    assign max_val  = {sign, {(EXP_WIDTH-1){1'b1}}, 1'b0, {SIG_WIDTH{1'b1}}};
    assign qnan_val = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(SIG_WIDTH-1){1'b0}}};

    always_comb begin
        ovf_val = inf_val;
        case (mode)
            RNE:     ovf_val = inf_val;
            RTZ:     ovf_val = max_val;
            RUP:     ovf_val = sign ? max_val : inf_val;
            RDN:     ovf_val = sign ? inf_val : max_val;
            default: ovf_val = inf_val;
        endcase
    end

    always_comb begin
        result_d = {sign, packed_res[SIG_WIDTH+EXP_WIDTH-1:0]};
        if (nan_a | nan_b)
            result_d = qnan_val;
        else if ((inf_a & zero_b) | (zero_a & inf_b))
            result_d = qnan_val;
        else if (inf_a | inf_b)
            result_d = inf_val;
        else if (zero_a | zero_b)
            result_d = {sign, {(WIDTH-1){1'b0}}};
        else if (overflow)
            result_d = ovf_val;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) result_q <= '0;
        else      result_q <= result_d;
    end

    assign result = result_q;

endmodule

// File: tb/tb_top.sv
// Self-checking bench for the binary32 multiplier: directed corner vectors,
// reset behaviour, then random operands against a quantum-based rounding model.
module tb_top;

    logic        clk;
    logic        rst;
    logic [31:0] A, B, result;
    logic [1:0]  rnd;

    int vectors     = 0;
    int miscompares = 0;

    top dut (
        .clk    (clk),
        .rst    (rst),
        .A      (A),
        .B      (B),
        .rnd    (rnd),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] overflowValue(input logic s, input logic [1:0] r);
        logic [31:0] infV, maxV;
        infV = {s, 8'hFF, 23'h000000};
        maxV = {s, 8'hFE, 23'h7FFFFF};
        case (r)
            2'b00:   return infV;
            2'b01:   return maxV;
            2'b10:   return s ? maxV : infV;
            default: return s ? infV : maxV;
        endcase
    endfunction

    // Value = m * 2^q; q is the finest quantum available to the result.
    function automatic logic [31:0] refMul(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] r);
        logic   s, up;
        logic   aNan, bNan, aInf, bInf, aZero, bZero;
        int     ea, eb, expA, expB, e, k, q, d, expField;
        longint ma, mb, p, m, rem, half;
        s     = a[31] ^ b[31];
        ea    = int'(a[30:23]);
        eb    = int'(b[30:23]);
        aNan  = (ea == 255) && (a[22:0] != 0);
        bNan  = (eb == 255) && (b[22:0] != 0);
        aInf  = (ea == 255) && (a[22:0] == 0);
        bInf  = (eb == 255) && (b[22:0] == 0);
        aZero = (ea == 0) && (a[22:0] == 0);
        bZero = (eb == 0) && (b[22:0] == 0);
        if (aNan || bNan) return 32'h7FC00000;
        if ((aInf && bZero) || (aZero && bInf)) return 32'h7FC00000;
        if (aInf || bInf) return {s, 8'hFF, 23'h000000};
        if (aZero || bZero) return {s, 31'h00000000};
        ma   = longint'(a[22:0]);
        mb   = longint'(b[22:0]);
        if (ea != 0) ma += longint'(1) << 23;
        if (eb != 0) mb += longint'(1) << 23;
        expA = (ea == 0) ? -149 : ea - 150;
        expB = (eb == 0) ? -149 : eb - 150;
        p    = ma * mb;
        e    = expA + expB;
        k    = 0;
        for (int i = 0; i < 48; i++) if (p[i]) k = i;
        q    = k + e - 23;
        if (q < -149) q = -149;
        d    = q - e;
        rem  = 0;
        half = 0;
        if (d <= 0) begin
            m = p << (-d);
        end else if (d > 60) begin
            m    = 0;
            rem  = 1;
            half = longint'(1) << 60;
        end else begin
            m    = p >> d;
            rem  = p & ((longint'(1) << d) - 1);
            half = longint'(1) << (d - 1);
        end
        case (r)
            2'b00:   up = (rem != 0) && ((rem > half) || ((rem == half) && m[0]));
            2'b01:   up = 1'b0;
            2'b10:   up = !s && (rem != 0);
            default: up = s && (rem != 0);
        endcase
        if (up) m++;
        if (m == (longint'(1) << 24)) begin
            m = longint'(1) << 23;
            q++;
        end
        if (m < (longint'(1) << 23)) return {s, 8'h00, m[22:0]};
        expField = q + 150;
        if (expField >= 255) return overflowValue(s, r);
        return {s, expField[7:0], m[22:0]};
    endfunction

    // Biased toward exponent classes that exercise specials, underflow and overflow.
    function automatic logic [31:0] randOperand();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 9))
            0: x[30:23] = 8'h00;
            1: begin
                   x[30:23] = 8'hFF;
                   if ($urandom_range(0, 1) == 1) x[22:0] = 23'h0;
               end
            2: x[30:0] = 31'h0;
            3: x[30:23] = 8'($urandom_range(1, 20));
            4: x[30:23] = 8'($urandom_range(230, 254));
            5, 6: x[30:23] = 8'($urandom_range(100, 154));
            default: ;
        endcase
        return x;
    endfunction

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [1:0] r);
        A   = a;
        B   = b;
        rnd = r;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] expected);
        vectors++;
        assert (result === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %08h expected %08h", tag, result, expected);
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [1:0]  rr;
        rst = 1'b1;
        A   = 32'h3F800000;
        B   = 32'h3F800000;
        rnd = 2'b00;
        #2 rst = 1'b0;
        #1 checkOutput("reset_initial", 32'h00000000);
        @(posedge clk);
        #1 checkOutput("reset_hold_edge", 32'h00000000);
        @(negedge clk);
        rst = 1'b1;

        applyStimulus(32'h3F800000, 32'h3F800000, 2'b00); checkOutput("one_x_one", 32'h3F800000);
        applyStimulus(32'h40000000, 32'h40400000, 2'b00); checkOutput("two_x_three", 32'h40C00000);
        applyStimulus(32'h3FC00000, 32'hC0000000, 2'b00); checkOutput("neg_product", 32'hC0400000);
        applyStimulus(32'h80000000, 32'h3F800000, 2'b00); checkOutput("neg_zero", 32'h80000000);
        applyStimulus(32'h7F800000, 32'h00000000, 2'b00); checkOutput("inf_x_zero", 32'h7FC00000);
        applyStimulus(32'h7FC00001, 32'h3F800000, 2'b00); checkOutput("nan_in", 32'h7FC00000);
        applyStimulus(32'hFF800000, 32'h40000000, 2'b00); checkOutput("neg_inf", 32'hFF800000);
        applyStimulus(32'h7F7FFFFF, 32'h40000000, 2'b00); checkOutput("ovf_rne", 32'h7F800000);
        applyStimulus(32'h7F7FFFFF, 32'h40000000, 2'b01); checkOutput("ovf_rtz", 32'h7F7FFFFF);
        applyStimulus(32'hFF7FFFFF, 32'h40000000, 2'b10); checkOutput("ovf_rup_neg", 32'hFF7FFFFF);
        applyStimulus(32'hFF7FFFFF, 32'h40000000, 2'b11); checkOutput("ovf_rdn_neg", 32'hFF800000);
        applyStimulus(32'h7F7FFFFF, 32'h40000000, 2'b11); checkOutput("ovf_rdn_pos", 32'h7F7FFFFF);
        applyStimulus(32'h00800000, 32'h3F000000, 2'b00); checkOutput("exact_subnormal", 32'h00400000);
        applyStimulus(32'h00000001, 32'h3E800000, 2'b00); checkOutput("underflow_rne", 32'h00000000);
        applyStimulus(32'h00000001, 32'h3E800000, 2'b10); checkOutput("underflow_rup", 32'h00000001);
        applyStimulus(32'h80000001, 32'h3E800000, 2'b11); checkOutput("underflow_rdn_neg", 32'h80000001);
        applyStimulus(32'h3F7FFFFF, 32'h3F800001, 2'b10); checkOutput("round_carry_rup", 32'h3F800001);

        // Mid-stream reset: result must clear between edges and stay clear.
        applyStimulus(32'h3F800000, 32'h3F800000, 2'b00); checkOutput("pre_reset", 32'h3F800000);
        A = 32'h40000000;
        B = 32'h40400000;
        @(negedge clk);
        rst = 1'b0;
        #1 checkOutput("reset_async", 32'h00000000);
        @(posedge clk);
        #1 checkOutput("reset_held", 32'h00000000);
        @(negedge clk);
        rst = 1'b1;
        #1 checkOutput("reset_released", 32'h00000000);
        @(posedge clk);
        #1 checkOutput("first_edge_after_reset", 32'h40C00000);

        for (int i = 0; i < 1500; i++) begin
            ra = randOperand();
            rb = randOperand();
            rr = 2'($urandom_range(0, 3));
            applyStimulus(ra, rb, rr);
            checkOutput($sformatf("rand%0d a=%08h b=%08h rnd=%0d", i, ra, rb, rr), refMul(ra, rb, rr));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
